// File: rtl/max7219_pkg.sv
// max7219_pkg
//   Shared constants for the MAX7219 serial path: register addresses,
//   the 16-bit frame width, the word transmitter state encoding and
//   small helpers used to size the phase counter.
//   No ports (package).
package max7219_pkg;

    // Width of one MAX7219 register write: {4'bx, addr[3:0], data[7:0]}
    localparam int WORD_W = 16;

    // MAX7219 register addresses
    localparam logic [3:0] NOOP      = 4'h0;
    localparam logic [3:0] DIGIT0    = 4'h1;
    localparam logic [3:0] DIGIT1    = 4'h2;
    localparam logic [3:0] DIGIT2    = 4'h3;
    localparam logic [3:0] DIGIT3    = 4'h4;
    localparam logic [3:0] DIGIT4    = 4'h5;
    localparam logic [3:0] DIGIT5    = 4'h6;
    localparam logic [3:0] DIGIT6    = 4'h7;
    localparam logic [3:0] DIGIT7    = 4'h8;
    localparam logic [3:0] DECODE    = 4'h9;
    localparam logic [3:0] INTENSITY = 4'hA;
    localparam logic [3:0] SCANLIMIT = 4'hB;
    localparam logic [3:0] SHUTDOWN  = 4'hC;
    localparam logic [3:0] DISPTEST  = 4'hF;

    // Word transmitter state encoding
    localparam int         ST_W        = 3;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold the load value n-1 of an n-cycle phase (at least 1).
    function automatic int timer_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max7219_word_tx_phase_timer.sv
// max7219_phase_timer
//   Loadable down-counter that times every fixed-length phase of a frame.
//   A phase of N cycles is started by loading N-1; the phase ends in the
//   cycle where zero_o is high.
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous, active-low reset (clears the count)
//     load_i   in   load value_i this cycle
//     value_i  in   [W-1:0] load value
//     zero_o   out  count is zero
module max7219_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign zero_o = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (!zero_o) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/max7219_word_tx.sv
// max7219_word_tx
//   Serializes one 16-bit MAX7219 register write per handshake, MSB first,
//   with cs held low across all 16 sclk periods; the cs rising edge latches
//   the register in the MAX7219.
//   Optional feature: define MAX7219_TXCNT_EN to add the tx_count output
//   (frames completed since reset, wrapping at 16 bits).
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous, active-low reset
//     word_in    in   [15:0] {4'bx, addr[3:0], data[7:0]}, captured on accept
//     valid      in   upstream has a word
//     ready      out  idle and able to accept (registered)
//     done       out  one-cycle pulse: frame complete and latched
//     mosi       out  serial data to MAX7219 DIN
//     sclk       out  serial clock, MAX7219 samples on its rising edge
//     cs         out  chip select / LOAD, active low
//     tx_count   out  [15:0] completed frames (MAX7219_TXCNT_EN only)
//     state_dbg  out  [2:0] current FSM state
//
// Handshake: a word is accepted at a clk edge where valid && ready. ready is
// a registered output that is high only in IDLE, so valid presented while
// ready is low is ignored and word_in is sampled only at the accept edge.
module max7219_word_tx
    import max7219_pkg::*;
#(
    parameter int CLK_DIV  = 25,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_in,
    input  logic              valid,
    output logic              ready,
    output logic              done,
    output logic              mosi,
    output logic              sclk,
    output logic              cs,
`ifdef MAX7219_TXCNT_EN
    output logic [15:0]       tx_count,
`endif
    output logic [ST_W-1:0]   state_dbg
);

    localparam int TW    = timer_width(max_of4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP));
    localparam int BIT_W = $clog2(WORD_W);

    localparam logic [TW-1:0]    LD_DIV   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]    LD_SETUP = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0]    LD_HOLD  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0]    LD_GAP   = TW'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic              cs_q, sclk_q, ready_q;
    logic              cs_d, sclk_d, ready_d;

    logic              tmr_load;
    logic [TW-1:0]     tmr_value;
    logic              tmr_zero;

    max7219_phase_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    // Each state is entered with the timer loaded for its own duration, so
    // every state simply waits for tmr_zero and loads the next duration.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state_q)
            ST_IDLE: begin
                mosi_d = 1'b0;
                if (valid && ready_q) begin
                    state_d   = ST_SETUP;
                    shift_d   = word_in;
                    bit_d     = BIT_LAST;
                    mosi_d    = word_in[WORD_W-1];
                    tmr_load  = 1'b1;
                    tmr_value = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d   = ST_SHIFT_LO;
                    tmr_load  = 1'b1;
                    tmr_value = LD_DIV;
                end
            end
            ST_SHIFT_LO: begin
                if (tmr_zero) begin
                    state_d   = ST_SHIFT_HI;
                    tmr_load  = 1'b1;
                    tmr_value = LD_DIV;
                end
            end
            ST_SHIFT_HI: begin
                if (tmr_zero) begin
                    shift_d  = shift_q << 1;
                    tmr_load = 1'b1;
                    if (bit_q != '0) begin
                        // Next bit goes out together with sclk falling.
                        bit_d     = bit_q - BIT_ONE;
                        state_d   = ST_SHIFT_LO;
                        mosi_d    = shift_d[WORD_W-1];
                        tmr_value = LD_DIV;
                    end else begin
                        // Last bit stays on mosi through HOLD and GAP.
                        state_d   = ST_HOLD;
                        tmr_value = LD_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_d   = ST_GAP;
                    tmr_load  = 1'b1;
                    tmr_value = LD_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // Pin levels are decoded from the next state so they change on the same
    // edge as the state register, with no combinational path to the pins.
    assign cs_d    = (state_d == ST_IDLE) || (state_d == ST_GAP);
    assign sclk_d  = (state_d == ST_SHIFT_HI);
    assign ready_d = (state_d == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            ready_q <= ready_d;
        end
    end

`ifdef MAX7219_TXCNT_EN
    logic [15:0] tx_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_count_q <= '0;
        end else if (done_q) begin
            tx_count_q <= tx_count_q + 16'd1;
        end
    end

    assign tx_count = tx_count_q;
`endif

    assign ready     = ready_q;
    assign done      = done_q;
    assign mosi      = mosi_q;
    assign sclk      = sclk_q;
    assign cs        = cs_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_max7219_word_tx.sv
// tb_max7219_word_tx
//   Bench for max7219_word_tx with CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, CS_GAP=2.
//   Define MAX7219_TXCNT_EN to also exercise tx_count.
module tb_max7219_word_tx;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 1;
    localparam int CS_GAP   = 2;
    // Accept edge to done: setup, 16 bits of two half-periods, hold, gap.
    localparam int LAT      = CS_SETUP + 32 * CLK_DIV + CS_HOLD + CS_GAP;
    // cs rises LAT-CS_GAP cycles after accept; a held valid is taken at the
    // edge closing the done cycle, LAT+1 cycles after the previous accept.
    localparam int GAP_B2B  = (LAT + 1) - (CS_SETUP + 32 * CLK_DIV + CS_HOLD);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] word_in = 16'h0000;
    logic        ready, done, mosi, sclk, cs;
    logic [2:0]  state_dbg;
`ifdef MAX7219_TXCNT_EN
    logic [15:0] tx_count;
`endif

    max7219_word_tx #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .word_in   (word_in),
        .valid     (valid),
        .ready     (ready),
        .done      (done),
        .mosi      (mosi),
        .sclk      (sclk),
        .cs        (cs),
`ifdef MAX7219_TXCNT_EN
        .tx_count  (tx_count),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    int          exp_len_q[$];
    int          exp_done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not match expectation (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor ----------------
    bit          mon_en = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic [15:0] rx = 16'h0000;
    int          nbits = 0;
    int          high_run = 0;
    int          last_gap = 0;
    int          mon_e;
    logic [15:0] mon_w;
    int          mon_len;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    mon_e = exp_done_q.pop_front();
                    check("done_cycle", cyc, mon_e);
                    check("ready_with_done", ready, 1);
                end
            end
            if (sclk && prev_sclk) check("mosi_stable_while_sclk_high", mosi, prev_mosi);
            if (sclk && !prev_sclk) begin
                check("cs_low_at_sclk_rise", cs, 0);
                rx = {rx[14:0], mosi};
                nbits++;
            end
            if (!cs && prev_cs) begin
                last_gap = high_run;
                rx       = 16'h0000;
                nbits    = 0;
            end
            if (cs && !prev_cs) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_frame");
                end else begin
                    mon_w   = exp_q.pop_front();
                    mon_len = exp_len_q.pop_front();
                    check("frame_bit_count", nbits, mon_len);
                    check("frame_data", rx, mon_w >> (16 - mon_len));
                end
            end
            high_run = cs ? high_run + 1 : 0;
        end
        prev_cs   = cs;
        prev_sclk = sclk;
        prev_mosi = mosi;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] w, input bit hold, input bit aborted, output int acc);
        word_in = w;
        valid   = 1'b1;
        acc     = -1;
        for (int i = 0; i < 400 && acc < 0; i++) begin
            @(negedge clk);
            if (ready) acc = cyc + 1;
        end
        if (acc < 0) begin
            fail_now("accept_timeout");
        end else begin
            exp_q.push_back(w);
            exp_len_q.push_back(aborted ? 8 : 16);
            if (!aborted) exp_done_q.push_back(acc + LAT);
        end
        @(posedge clk); #1;
        if (!hold) valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk);
            if (exp_done_q.size() == 0 && exp_q.size() == 0 && ready) idle = 1'b1;
        end
        if (!idle) fail_now("idle_timeout");
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    int acc1, acc2, rises;
    logic ps;

    initial begin
        // 1. reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
`ifdef MAX7219_TXCNT_EN
        check("rst_tx_count", tx_count, 0);
`endif
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", ready, 0);
        @(negedge clk);
        check("ready_after_release", ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_sclk", sclk, 0);
            check("idle_cs", cs, 1);
        end
        @(posedge clk); #1;

        // 2. single frame, then random frames with random idle spacing
        send(16'h0C01, 1'b0, 1'b0, acc1);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            send(16'($urandom), 1'b0, 1'b0, acc1);
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end

        // 3. back-to-back with valid held
        send(16'h0A0A, 1'b1, 1'b0, acc1);
        send(16'h0B07, 1'b0, 1'b0, acc2);
        check("b2b_accept_cycle", acc2, acc1 + LAT + 1);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_cs_high_cycles", last_gap, GAP_B2B);
        wait_idle();

        // 4. word_in / valid changes during a frame are ignored
        send(16'h0F00, 1'b0, 1'b0, acc1);
        word_in = 16'hFFFF;
        valid   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("ready_low_while_busy", ready, 0);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        // 5. reset after the 8th sclk rise
        send(16'h0103, 1'b0, 1'b1, acc1);
        rises = 0;
        ps    = sclk;
        for (int i = 0; i < 200 && rises < 8; i++) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        check("abort_rises_seen", rises, 8);
        reset = 1'b0;
        @(negedge clk);
        check("abort_cs", cs, 1);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_done", done, 0);
        check("abort_ready", ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready_before_edge", ready, 0);
        @(negedge clk);
        check("abort_ready_after_release", ready, 1);
        @(posedge clk); #1;

        // 6. three random frames (frame counter when enabled)
        for (int k = 0; k < 3; k++) begin
            send(16'($urandom), 1'b0, 1'b0, acc1);
            wait_idle();
        end
`ifdef MAX7219_TXCNT_EN
        @(posedge clk); #1;
        check("tx_count_three", tx_count, 3);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("tx_count_reset", tx_count, 0);
        @(posedge clk); #1;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("exp_frames_left", exp_q.size(), 0);
        check("exp_done_left", exp_done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
